// File: rtl/codec_bridge_pkg.sv
// rtl/codec_bridge_pkg.sv - shared types and defaults for the codec/FIR bridge
//   DEF_DW / DEF_FW / DEF_DEPTH : default codec width, filter width, FIFO depth
//   pair_t                      : stereo sample pair {l, r}
//   in_state_t / out_state_t    : input and output FSM encodings
package codec_bridge_pkg;

  localparam int DEF_DW    = 24;
  localparam int DEF_FW    = 16;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_DW-1:0] l;
    logic [DEF_DW-1:0] r;
  } pair_t;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_POP  = 2'd1,
    IN_HOLD = 2'd2
  } in_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_WR   = 1'b1
  } out_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
//   ck, rst_n   : clock, asynchronous active-low reset
//   push, din   : write strobe and data (accepted when not full, or full with a pop)
//   pop         : read strobe (ignored when empty)
//   head        : oldest entry (undefined content when empty)
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers carry one extra wrap bit, so the plain difference is the occupancy.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/codec_fir_bridge.sv
// rtl/codec_fir_bridge.sv - pairs codec ADC samples with right-channel FIR results
//   ck, rst_n                          : clock, asynchronous active-low reset
//   read_ready, readdata_left/right    : codec ADC pair, level valid
//   read                               : one-cycle pop strobe to the codec
//   write_ready                        : codec can take a DAC pair
//   write, writedata_left/right        : one-cycle DAC push strobe and pair
//   fir_in, fir_in_valid               : truncated right sample to the filter
//   fir_out, fir_out_valid             : filter result strobe
//   orphan_err                         : sticky, result arrived with no left sample waiting
module codec_fir_bridge
  import codec_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int FW    = DEF_FW
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic          write_ready,
  output logic          write,
  output logic [DW-1:0] writedata_left,
  output logic [DW-1:0] writedata_right,
  output logic [FW-1:0] fir_in,
  output logic          fir_in_valid,
  input  logic [FW-1:0] fir_out,
  input  logic          fir_out_valid,
  output logic          orphan_err
);

  localparam int AW = $clog2(DEPTH);

  in_state_t       in_st, in_nxt;
  out_state_t      out_st, out_nxt;

  logic [DW-1:0]   left_head;
  logic [AW:0]     left_count;
  logic            left_full, left_empty, left_pop;

  logic [2*DW-1:0] out_din, out_head;
  logic [AW:0]     out_count;
  logic            out_full, out_empty, out_pop;

  logic [AW+1:0]   inflight;
  logic            admit;
  logic            unused_rd_lsbs;

  // Samples held anywhere between the codec read and the DAC write; capping
  // this at DEPTH keeps both FIFOs from ever overflowing.
  assign inflight = {1'b0, left_count} + {1'b0, out_count};
  assign admit    = (inflight < (AW+2)'(DEPTH));

  assign left_pop = fir_out_valid && !left_empty;
  assign out_din  = {left_head, fir_out, {(DW-FW){1'b0}}};
  assign out_pop  = (out_st == OUT_WR);

  sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_left_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .push  (in_st == IN_POP),
    .din   (readdata_left),
    .pop   (left_pop),
    .head  (left_head),
    .count (left_count),
    .full  (left_full),
    .empty (left_empty)
  );

  sync_fifo #(.W(2*DW), .DEPTH(DEPTH)) u_out_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .push  (left_pop),
    .din   (out_din),
    .pop   (out_pop),
    .head  (out_head),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      in_st      <= IN_IDLE;
      out_st     <= OUT_IDLE;
      fir_in     <= '0;
      orphan_err <= 1'b0;
    end else begin
      in_st  <= in_nxt;
      out_st <= out_nxt;
      if (in_st == IN_POP) fir_in <= readdata_right[DW-1:DW-FW];
      if (fir_out_valid && left_empty) orphan_err <= 1'b1;
    end
  end

  // HOLD exists so the codec has a cycle to present its next pair before
  // read_ready is looked at again.
  always_comb begin
    in_nxt       = in_st;
    read         = 1'b0;
    fir_in_valid = 1'b0;
    case (in_st)
      IN_IDLE: if (read_ready && admit) in_nxt = IN_POP;
      IN_POP: begin
        read   = 1'b1;
        in_nxt = IN_HOLD;
      end
      IN_HOLD: begin
        fir_in_valid = 1'b1;
        in_nxt       = IN_IDLE;
      end
      default: in_nxt = IN_IDLE;
    endcase
  end

  always_comb begin
    out_nxt = out_st;
    write   = 1'b0;
    case (out_st)
      OUT_IDLE: if (write_ready && !out_empty) out_nxt = OUT_WR;
      OUT_WR: begin
        write   = 1'b1;
        out_nxt = OUT_IDLE;
      end
      default: out_nxt = OUT_IDLE;
    endcase
  end

  assign writedata_left  = out_empty ? '0 : out_head[2*DW-1:DW];
  assign writedata_right = out_empty ? '0 : out_head[DW-1:0];

  assign unused_rd_lsbs = ^readdata_right[DW-FW-1:0];

  a_out_no_overflow: assert property (@(posedge ck) disable iff (!rst_n)
    !(left_pop && out_full && !out_pop));
  a_left_no_overflow: assert property (@(posedge ck) disable iff (!rst_n)
    !((in_st == IN_POP) && left_full && !left_pop));

endmodule

// File: doc/codec_fir_bridge.md
# codec_fir_bridge

Stream adapter between `audio_codec` and the right-channel `fir` filter. It turns the codec's level-style `read_ready`/`write_ready` into single-cycle `read`/`write` strobes, truncates the right sample into the filter, and delays the left sample so it stays paired with its filtered right sample. It buffers finished stereo pairs until the codec accepts them and bounds the number of samples in flight, so no buffer can overflow.

## Interface
Parameters:
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `DW`, 24: codec sample width.
- `FW`, 16: filter sample width.

Ports:
- `ck` in 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `read_ready` in 1: codec has an ADC sample pair.
- `readdata_left`, `readdata_right` in DW: ADC pair; valid while `read_ready` is high.
- `read` out 1: one-cycle pop strobe to the codec.
- `write_ready` in 1: codec can accept a DAC pair.
- `write` out 1: one-cycle push strobe to the codec.
- `writedata_left`, `writedata_right` out DW: DAC pair; valid while `write` is high.
- `fir_in` out FW: filter input, `readdata_right[DW-1:DW-FW]`.
- `fir_in_valid` out 1: one-cycle strobe to the filter.
- `fir_out` in FW: filter result.
- `fir_out_valid` in 1: one-cycle strobe from the filter.
- `orphan_err` out 1: sticky error flag.

## Operation
- **In-flight count.** `inflight = left_count + out_count`. A read is admitted only when `inflight < DEPTH`.
- **Input FSM states:** IDLE, POP, HOLD.
  - IDLE → POP when `read_ready` is high and admission holds.
  - POP: assert `read`. Capture `readdata_left` into the left FIFO (push) and `readdata_right[DW-1:DW-FW]` into the `fir_in` register. → HOLD.
  - HOLD: assert `fir_in_valid`. Ignore `read_ready` so the codec can update. → IDLE.
- **Pairing.** On `fir_out_valid`, pop the left FIFO head and push `{left, {fir_out, 8'h00}}` into the output FIFO. `writedata_right` is `fir_out` zero-extended in the LSBs (no saturation, no rounding).
- **Orphan result.** If `fir_out_valid` arrives while the left FIFO is empty: drop the result, set `orphan_err`. It stays set until reset.
- **Output FSM states:** IDLE, WR.
  - IDLE → WR when `write_ready` is high and the output FIFO is non-empty.
  - WR: assert `write` with `writedata_*` = head, pop the head. → IDLE, so there is always a one-cycle gap between writes.
- **Outputs when not writing.** `writedata_*` show the output FIFO head, or 0 when it is empty.
- **Overflow.** Output-FIFO overflow is unreachable because of the admission rule. It is asserted as a design invariant.
- **Simultaneous events.**
  - Push and pop on the same FIFO in one cycle: legal; count unchanged; data ordering preserved.
  - `fir_out_valid` in the same cycle as a POP push: both act; the pop takes the older head.
  - `fir_out_valid` in the same cycle as a WR pop: both act.

## Timing
- **Reset values:** `read`, `write`, `fir_in_valid` = 0; `fir_in`, `writedata_*` = 0; `orphan_err` = 0; both FIFOs empty; both FSMs in IDLE.
- **Reset mid-operation:** all in-flight samples are discarded. Any `fir_out_valid` arriving after reset with the left FIFO empty sets `orphan_err`. This is the accepted cost.
- **Input path:** `read_ready` seen high at cycle T → `read` at T+1 → `fir_in_valid` at T+2. Peak rate is one sample every 3 cycles.
- **Output path:** `fir_out_valid` at cycle F → `write` earliest at F+2 (the pair is pushed at the F edge; the output FSM samples non-empty at F+1).
- **Wrap-around:** pointers are log2(DEPTH) bits plus a wrap bit; count = wrap-aware difference.

## Structure
- **Package `codec_bridge_pkg`:** default `DW`/`FW`, `typedef struct packed {logic [DW-1:0] l, r;} pair_t`, and the FSM state enums.
- **Sub-module `sync_fifo`** (parameterised width/depth, async active-low reset, `push`, `pop`, `head`, `count`, `full`, `empty`). Instantiated twice: left FIFO at width DW, output FIFO at width 2·DW.

## Test plan
- **Single sample.** `read_ready`=1, L=0x123456, R=0xABCDEF → `read` at T+1, `fir_in`=0xABCD with `fir_in_valid` at T+2. Return `fir_out`=0x1111; `write_ready`=1 → `write` with L=0x123456, R=0x111100.
- **Backpressure.** Hold `write_ready`=0 and the filter echoes instantly → exactly DEPTH `read` strobes, then `read` stays low. Raise `write_ready` → 4 writes in order, reads resume.
- **Order under stress.** 100 pairs with a random filter latency of 1–20 cycles → DAC L sequence equals ADC L sequence; each R equals the returned `fir_out` padded with `8'h00`.
- **Orphan result.** `fir_out_valid` with nothing in flight → no `write`, `orphan_err`=1 and held across later traffic.
- **Simultaneous push/pop.** Force `fir_out_valid` in the same cycle as a POP and as a WR → counts stay consistent, no sample lost or duplicated.
- **Mid-operation reset.** Assert `rst_n`=0 with 3 samples in flight → all outputs 0 on the next edge, `write` never fires for the stale samples.
